// File: rtl/reg_write_pkg.sv
// Shared types and sizes for the register write controller.
// The entry struct is the FIFO payload, so its field order fixes the FIFO word layout.
package reg_write_pkg;

    localparam int NREG  = 8;
    localparam int SEL_W = 3;
    localparam int BE_W  = 2;
    localparam int DW    = 16;
    localparam int LANE_W = DW / BE_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [BE_W-1:0]  be;
        logic [DW-1:0]    data;
    } wr_entry_t;

endpackage

// File: rtl/reg_write_ctrl_if.sv
// Write request channel: valid/ready request plus the commit-done report.
interface reg_write_ctrl_if #(parameter int DATA_W = 16);
    import reg_write_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              wr_done;
    logic [SEL_W-1:0]  wr_done_sel;

    modport master (
        output wr_valid, wr_sel, wr_data, wr_be,
        input  wr_ready, wr_done, wr_done_sel
    );

    modport slave (
        input  wr_valid, wr_sel, wr_data, wr_be,
        output wr_ready, wr_done, wr_done_sel
    );

endinterface

// File: rtl/reg_write_ctrl_sync_fifo.sv
// Small synchronous FIFO; full/empty come from pointers only, no same-cycle bypass.
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop)  rp <= rp + (AW+1)'(1);
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

    assign dout  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/reg_write_ctrl.sv
// Owns reg0..reg7: queued byte-masked writes, one commit per cycle,
// plus a sequenced clear-all that zeroes one register per cycle.
module reg_write_ctrl
    import reg_write_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    reg_write_ctrl_if.slave   bus,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [DATA_W-1:0] reg0,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] reg3,
    output logic [DATA_W-1:0] reg4,
    output logic [DATA_W-1:0] reg5,
    output logic [DATA_W-1:0] reg6,
    output logic [DATA_W-1:0] reg7
);
    state_t                       state, state_nx;
    logic [SEL_W-1:0]             cnt;
    logic [NREG-1:0][DATA_W-1:0]  regs;
    wr_entry_t                    push_ent, head;
    logic                         push, pop, full, empty;

    assign push_ent = '{sel: bus.wr_sel, be: bus.wr_be, data: bus.wr_data};
    assign push     = bus.wr_valid && !full;
    assign bus.wr_ready = !full;

    sync_fifo #(.DEPTH(DEPTH), .W($bits(wr_entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (clr_start) state_nx = CLEAR;
            CLEAR:   if (cnt == SEL_W'(NREG-1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Clear wins over a pending commit; the entry waits in the FIFO.
    always_comb begin
        clr_busy = (state == CLEAR);
        pop      = (state == IDLE) && !empty && !clr_start;
    end

    always_ff @(posedge clk) begin
        if (rst)                  cnt <= '0;
        else if (state == CLEAR)  cnt <= cnt + SEL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs            <= '0;
            bus.wr_done     <= 1'b0;
            bus.wr_done_sel <= '0;
        end else begin
            bus.wr_done <= pop;
            if (state == CLEAR) begin
                regs[cnt] <= '0;
            end else if (pop) begin
                bus.wr_done_sel <= head.sel;
                for (int l = 0; l < BE_W; l++)
                    if (head.be[l])
                        regs[head.sel][l*LANE_W +: LANE_W] <= head.data[l*LANE_W +: LANE_W];
            end
        end
    end

    assign reg0 = regs[0];
    assign reg1 = regs[1];
    assign reg2 = regs[2];
    assign reg3 = regs[3];
    assign reg4 = regs[4];
    assign reg5 = regs[5];
    assign reg6 = regs[6];
    assign reg7 = regs[7];

endmodule
